// File: rtl/timer_intr_ctrl.sv
// Machine timer (64-bit mtime/mtimecmp), software interrupt bit and two
// synchronised, edge-latched external lines, aggregated onto a 4-bit interrupt bus.
module timer_intr_ctrl #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        we,
  input  logic [2:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [1:0]  ext_irq,
  output logic [3:0]  interrupt
);

  typedef enum logic [2:0] {
    REG_MTIME_LO    = 3'd0,
    REG_MTIME_HI    = 3'd1,
    REG_MTIMECMP_LO = 3'd2,
    REG_MTIMECMP_HI = 3'd3,
    REG_MSIP        = 3'd4,
    REG_EXT_PEND    = 3'd5,
    REG_STATUS      = 3'd6,
    REG_UNMAPPED    = 3'd7
  } reg_idx_e;

  localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);

  logic [15:0] presc_q, presc_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic        timer_pend_q, timer_pend_d;
  logic [1:0]  ext_pend_q, ext_pend_d;
  logic [1:0]  sync1_q, sync2_q, sync3_q;

  reg_idx_e    idx;
  logic        wr_en;
  logic        wr_mtime_lo, wr_mtime_hi;
  logic        tick;
  logic [1:0]  ext_rise;
  logic [1:0]  ext_clr;

  assign idx         = reg_idx_e'(addr);
  assign wr_en       = sel & we;
  assign wr_mtime_lo = wr_en && (idx == REG_MTIME_LO);
  assign wr_mtime_hi = wr_en && (idx == REG_MTIME_HI);
  assign tick        = (presc_q == PRESC_LAST);
  assign ext_rise    = sync2_q & ~sync3_q;
  assign ext_clr     = (wr_en && (idx == REG_EXT_PEND)) ? wdata[1:0] : 2'b00;

  // NOTE: every variable gets a default at the top of an always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    presc_d      = tick ? 16'd0 : presc_q + 16'd1;
    mtime_d      = mtime_q;
    mtimecmp_d   = mtimecmp_q;
    msip_d       = msip_q;
    timer_pend_d = (mtime_q >= mtimecmp_q);
    // Set wins over a simultaneous write-1-to-clear.
    ext_pend_d   = (ext_pend_q & ~ext_clr) | ext_rise;

    // A bus write to either mtime half suppresses the increment and carry that cycle.
    if (wr_mtime_lo) begin
      mtime_d[31:0] = wdata;
      presc_d       = 16'd0;
    end else if (wr_mtime_hi) begin
      mtime_d[63:32] = wdata;
      presc_d        = 16'd0;
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end

    if (wr_en) begin
      case (idx)
        REG_MTIMECMP_LO: mtimecmp_d[31:0]  = wdata;
        REG_MTIMECMP_HI: mtimecmp_d[63:32] = wdata;
        REG_MSIP:        msip_d            = wdata[0];
        default:         ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q      <= 16'd0;
      mtime_q      <= 64'd0;
      mtimecmp_q   <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_q       <= 1'b0;
      timer_pend_q <= 1'b0;
      ext_pend_q   <= 2'b00;
      sync1_q      <= 2'b00;
      sync2_q      <= 2'b00;
      sync3_q      <= 2'b00;
    end else begin
      presc_q      <= presc_d;
      mtime_q      <= mtime_d;
      mtimecmp_q   <= mtimecmp_d;
      msip_q       <= msip_d;
      timer_pend_q <= timer_pend_d;
      ext_pend_q   <= ext_pend_d;
      // sync1/sync2 form the metastability synchroniser; sync3 is the edge-detect history.
      sync1_q      <= ext_irq;
      sync2_q      <= sync1_q;
      sync3_q      <= sync2_q;
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (sel) begin
      case (idx)
        REG_MTIME_LO:    rdata = mtime_q[31:0];
        REG_MTIME_HI:    rdata = mtime_q[63:32];
        REG_MTIMECMP_LO: rdata = mtimecmp_q[31:0];
        REG_MTIMECMP_HI: rdata = mtimecmp_q[63:32];
        REG_MSIP:        rdata = {31'd0, msip_q};
        REG_EXT_PEND:    rdata = {30'd0, ext_pend_q};
        REG_STATUS:      rdata = {28'd0, msip_q, ext_pend_q, timer_pend_q};
        REG_UNMAPPED:    rdata = 32'd0;
        default:         rdata = 32'd0;
      endcase
    end
  end

  assign interrupt = {msip_q, ext_pend_q, timer_pend_q};

endmodule

// File: tb/tb_timer_intr_ctrl.sv
// Directed bench for timer_intr_ctrl: expectations queued as stimulus is driven,
// popped and compared against the DUT with immediate assertions.
module tb_timer_intr_ctrl;

  logic        clk;
  logic        rst;
  logic        sel, we;
  logic [2:0]  addr;
  logic [31:0] wdata, rdata;
  logic [1:0]  ext_irq;
  logic [3:0]  interrupt;

  logic        sel4, we4;
  logic [2:0]  addr4;
  logic [31:0] wdata4, rdata4;
  logic [1:0]  ext_irq4;
  logic [3:0]  interrupt4;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp;
  int   n_mis;

  timer_intr_ctrl #(.TICK_DIV(1)) dut (
    .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ext_irq(ext_irq), .interrupt(interrupt)
  );

  timer_intr_ctrl #(.TICK_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .sel(sel4), .we(we4), .addr(addr4), .wdata(wdata4),
    .rdata(rdata4), .ext_irq(ext_irq4), .interrupt(interrupt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic push_exp(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_mis++;
      $error("FAIL scoreboard_empty observed=%h required=<queued value>", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp)
      else begin
        n_mis++;
        $error("FAIL %s observed=%h required=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  // Write occurs on the posedge between the calling negedge and the return negedge.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    sel = 1'b0; we = 1'b0; wdata = 32'd0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    sel = 1'b1; we = 1'b0; addr = a;
    #1;
    d = rdata;
  endtask

  initial begin
    logic [31:0] v;
    int          n;

    n_cmp = 0; n_mis = 0;
    rst = 1'b1; sel = 1'b0; we = 1'b0; addr = 3'd0; wdata = 32'd0; ext_irq = 2'b00;
    sel4 = 1'b1; we4 = 1'b0; addr4 = 3'd0; wdata4 = 32'd0; ext_irq4 = 2'b00;

    // Reset
    #2 rst = 1'b0;
    #1;
    push_exp("irq_in_reset", 32'd0); check({28'd0, interrupt});
    repeat (3) @(negedge clk);
    rst = 1'b1;
    push_exp("irq_after_reset", 32'd0); check({28'd0, interrupt});
    rd(3'd2, v); push_exp("mtimecmp_lo_reset", 32'hFFFF_FFFF); check(v);
    rd(3'd3, v); push_exp("mtimecmp_hi_reset", 32'hFFFF_FFFF); check(v);
    rd(3'd0, v); push_exp("mtime_lo_reset", 32'd0); check(v);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      rd(3'd0, v); push_exp($sformatf("mtime_count_%0d", i), 32'(i)); check(v);
    end

    // Timer fire and clear
    wr(3'd3, 32'd0);
    wr(3'd2, 32'd20);
    n = 0;
    rd(3'd0, v);
    while (v != 32'd20 && n < 100) begin
      @(negedge clk);
      rd(3'd0, v);
      n++;
    end
    push_exp("mtime_reach_20", 32'd20); check(v);
    push_exp("timer_irq_at_match", 32'd0); check({31'd0, interrupt[0]});
    @(negedge clk);
    push_exp("timer_irq_after_match", 32'd1); check({31'd0, interrupt[0]});
    push_exp("status_timer", 32'd1); wr(3'd2, 32'd1000);
    rd(3'd6, v); check(v);
    push_exp("timer_irq_cmp_write_edge", 32'd1); check({31'd0, interrupt[0]});
    @(negedge clk);
    push_exp("timer_irq_cleared", 32'd0); check({31'd0, interrupt[0]});

    // Write priority and rollover
    push_exp("mtime_lo_write_no_inc", 32'hFFFF_FFFF);
    push_exp("mtime_hi_before_carry", 32'd0);
    wr(3'd0, 32'hFFFF_FFFF);
    rd(3'd0, v); check(v);
    rd(3'd1, v); check(v);
    @(negedge clk);
    rd(3'd0, v); push_exp("mtime_lo_after_carry", 32'd0); check(v);
    rd(3'd1, v); push_exp("mtime_hi_after_carry", 32'd1); check(v);
    wr(3'd1, 32'hFFFF_FFFF);
    wr(3'd0, 32'hFFFF_FFFF);
    rd(3'd0, v); push_exp("mtime_lo_all_ones", 32'hFFFF_FFFF); check(v);
    rd(3'd1, v); push_exp("mtime_hi_all_ones", 32'hFFFF_FFFF); check(v);
    @(negedge clk);
    rd(3'd0, v); push_exp("mtime_lo_wrap", 32'd0); check(v);
    rd(3'd1, v); push_exp("mtime_hi_wrap", 32'd0); check(v);
    wr(3'd2, 32'hFFFF_FFFF);
    wr(3'd3, 32'hFFFF_FFFF);
    @(negedge clk);
    push_exp("irq_idle", 32'd0); check({28'd0, interrupt});

    // External edge, W1C, held level, re-arm
    ext_irq[0] = 1'b1;
    @(negedge clk); push_exp("ext0_edge1", 32'd0); check({31'd0, interrupt[1]});
    @(negedge clk); push_exp("ext0_edge2", 32'd0); check({31'd0, interrupt[1]});
    @(negedge clk); push_exp("ext0_edge3", 32'd1); check({31'd0, interrupt[1]});
    rd(3'd5, v); push_exp("ext_pend_read", 32'd1); check(v);
    rd(3'd6, v); push_exp("status_ext0", 32'd2); check(v);
    wr(3'd5, 32'd1);
    push_exp("ext0_w1c", 32'd0); check({31'd0, interrupt[1]});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      push_exp($sformatf("ext0_held_%0d", i), 32'd0); check({31'd0, interrupt[1]});
    end
    rd(3'd5, v); push_exp("ext_pend_after_w1c", 32'd0); check(v);
    ext_irq[0] = 1'b0;
    repeat (4) @(negedge clk);
    ext_irq[0] = 1'b1;
    repeat (3) @(negedge clk);
    push_exp("ext0_rearm", 32'd1); check({31'd0, interrupt[1]});

    // Simultaneous set and W1C on ext_pend[1]
    ext_irq[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    push_exp("set_wins_irq", 32'b0110);
    wr(3'd5, 32'd2);
    check({28'd0, interrupt});
    rd(3'd5, v); push_exp("set_wins_pend", 32'd3); check(v);
    wr(3'd5, 32'd2);
    rd(3'd5, v); push_exp("ext1_w1c_held", 32'd1); check(v);

    // MSIP, unmapped index, deselected bus
    wr(3'd4, 32'hFFFF_FFFF);
    push_exp("msip_irq", 32'b1010); check({28'd0, interrupt});
    rd(3'd4, v); push_exp("msip_read", 32'd1); check(v);
    rd(3'd6, v); push_exp("status_msip_ext0", 32'hA); check(v);
    wr(3'd7, 32'hFFFF_FFFF);
    rd(3'd7, v); push_exp("unmapped_read", 32'd0); check(v);
    sel = 1'b0; addr = 3'd4;
    #1;
    push_exp("rdata_unselected", 32'd0); check(rdata);

    // Asynchronous reset mid-run, then prescaler on the TICK_DIV=4 instance
    ext_irq = 2'b00;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    push_exp("irq_async_reset", 32'd0); check({28'd0, interrupt});
    @(negedge clk);
    rst = 1'b1;
    rd(3'd0, v); push_exp("mtime_after_reset", 32'd0); check(v);
    rd(3'd4, v); push_exp("msip_after_reset", 32'd0); check(v);
    push_exp("presc_k0", 32'd0); check(rdata4);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      #1;
      push_exp($sformatf("presc_k%0d", k), 32'(k / 4)); check(rdata4);
    end
    push_exp("irq_after_reset_run", 32'd0); check({28'd0, interrupt});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
